// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC generation, inst SRAM request issue,
// one-entry hold buffer for back-pressure, and delivery of {inst, pc} to decode.
//
// Handshake: fs_to_ds_valid / ds_allowin. An instruction moves to decode on a
// rising edge where fs_to_ds_valid=1 and ds_allowin=1. While ds_allowin=0 the
// stage holds fs_pc and its instruction. On a new SRAM request, fs_valid is set
// and the data arrives one cycle later on inst_sram_rdata.
module if_stage #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          FS_TO_DS_BUS_WD = 64,
    parameter int          BR_BUS_WD       = 34
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [31:0]                inst_sram_rdata
);

    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        buf_valid;
    logic [31:0] buf_inst;
    logic        req_pending;

    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        to_fs_valid;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic [31:0] fs_inst;

    assign br_stall  = br_bus[33];
    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    // Pre-IF: sequential or redirected next PC (mod 2^32, misaligned targets pass through)
    always_comb begin
        seq_pc      = fs_pc + 32'd4;
        nextpc      = br_taken ? br_target : seq_pc;
        to_fs_valid = ~reset;
        fs_ready_go = 1'b1;
        fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin);
        // A stalled branch wins over a taken one: nothing is fetched until it resolves
        inst_sram_en = to_fs_valid & fs_allowin & ~br_stall;
    end

    assign inst_sram_addr  = nextpc;
    assign inst_sram_we    = 4'h0;
    assign inst_sram_wdata = 32'h0;

    // Buffered word takes priority: SRAM output is only valid the cycle after a request
    assign fs_inst = buf_valid ? buf_inst : inst_sram_rdata;

    // Wrong-path (taken) and unresolved (stall) cases are never presented as valid
    assign fs_to_ds_valid = fs_valid & ~br_taken & ~br_stall;
    assign fs_to_ds_bus   = {fs_inst, fs_pc};

    // Fetch state: PC/valid update on request, squash on stall, buffer capture on back-pressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_valid    <= 1'b0;
            fs_pc       <= RESET_PC - 32'd4;
            buf_valid   <= 1'b0;
            buf_inst    <= 32'h0;
            req_pending <= 1'b0;
        end else if (inst_sram_en) begin
            fs_valid    <= 1'b1;
            fs_pc       <= nextpc;
            req_pending <= 1'b1;
            buf_valid   <= 1'b0;
        end else begin
            req_pending <= 1'b0;
            if (br_stall && fs_allowin) begin
                // Old instruction leaves (or is dropped); the slot empties
                fs_valid  <= 1'b0;
                buf_valid <= 1'b0;
            end else if (fs_valid && req_pending && !ds_allowin && !buf_valid) begin
                // SRAM data is only good this one cycle; keep it while decode is busy
                buf_inst  <= inst_sram_rdata;
                buf_valid <= 1'b1;
            end
        end
    end

endmodule
